// File: rtl/pipe_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//
// Groups the signals that pass between the pipeline datapath and the hazard
// controller into one bundle.
//
// Parameters
//   CNT_W          width of the two performance counters
//
// Signals (pipeline -> controller)
//   id_instr       instruction in the decode/branch stage
//   ex_rd          destination register of the instruction in EX
//   ex_reg_write   EX instruction writes a register
//   ex_mem_read    EX instruction is a load
//   br_mispredict  branch compare says taken; not-taken was predicted
//
// Signals (controller -> pipeline)
//   stallF/stallD  hold PC and IF/ID register
//   flushF/flushD  clear IF/ID and ID/EX contents
//   flushE         insert a bubble into EX
//   pc_sel         select the branch target at the PC mux
//   branch_dhazard branch operand source select
//   flush_cnt      saturating count of accepted redirects
//   stall_cnt      saturating count of stall cycles
//
// Modports
//   master         pipeline side (drives decode/EX information)
//   slave          hazard controller side
// -----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);

   logic [31:0]      id_instr;
   logic [4:0]       ex_rd;
   logic             ex_reg_write;
   logic             ex_mem_read;
   logic             br_mispredict;

   logic             stallF;
   logic             stallD;
   logic             flushF;
   logic             flushD;
   logic             flushE;
   logic             pc_sel;
   logic [1:0]       branch_dhazard;
   logic [CNT_W-1:0] flush_cnt;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_instr,
      output ex_rd,
      output ex_reg_write,
      output ex_mem_read,
      output br_mispredict,
      input  stallF,
      input  stallD,
      input  flushF,
      input  flushD,
      input  flushE,
      input  pc_sel,
      input  branch_dhazard,
      input  flush_cnt,
      input  stall_cnt
   );

   modport slave (
      input  id_instr,
      input  ex_rd,
      input  ex_reg_write,
      input  ex_mem_read,
      input  br_mispredict,
      output stallF,
      output stallD,
      output flushF,
      output flushD,
      output flushE,
      output pc_sel,
      output branch_dhazard,
      output flush_cnt,
      output stall_cnt
   );

endinterface

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard controller for a five-stage pipeline that resolves branches in
// decode. It detects load-use hazards against the instruction in EX, stalls
// the front end for one cycle when needed, and redirects the PC on a branch
// mispredict, flushing the wrong-path instructions.
//
// Parameters
//   FLUSH_CYCLES   1..3, number of FLUSH-state cycles following a redirect
//   CNT_W          width of the flush/stall performance counters
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   hz             pipe_hazard_ctrl_if.slave bundle (see interface file)
//
// Build option
//   BRANCH_FWD_EN  when defined, an ALU-result match on a branch operand is
//                  resolved by forwarding (branch_dhazard) instead of stalling.
//                  When undefined, branch_dhazard is tied to 0 and any such
//                  match costs one stall cycle.
//
// Behaviour summary
//   - Stall and redirect outputs are combinational from inputs and state.
//   - In RUN, a stall condition wins over a mispredict in the same cycle.
//   - A redirect is accepted only in RUN, for a branch, with no stall. The
//     acceptance cycle raises pc_sel/flushF/flushD; the FSM then spends
//     FLUSH_CYCLES cycles in FLUSH with flushF/flushD high and pc_sel low.
//   - br_mispredict is ignored in STALL and FLUSH so a held mispredict
//     cannot cause back-to-back redirects.
//   - All control outputs are forced low while rst_n is low.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 16
) (
   input logic               clk,
   input logic               rst_n,
   pipe_hazard_ctrl_if.slave hz
);

   typedef enum logic [1:0] {
      StRun,
      StStall,
      StFlush
   } state_e;

   // Index of the final FLUSH cycle for the internal flush counter.
   localparam logic [1:0] FlushLast = 2'(FLUSH_CYCLES - 1);

   state_e           state_q, state_d;
   logic [1:0]       fcnt_q, fcnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic [4:0]       rs1;
   logic [4:0]       rs2;
   logic             is_branch;
   logic             match_rs1;
   logic             match_rs2;
   logic             load_use;
   logic             stall_cond;
   logic [1:0]       fwd_sel;
   logic             in_run;
   logic             stall_out;
   logic             mp_accept;

   logic             stall_f;
   logic             stall_d;
   logic             flush_f;
   logic             flush_d;
   logic             flush_e;
   logic             pc_sel;
   logic [1:0]       dhazard;

   // ---------------------------------------------------------------------------
   // Decode and hazard detection
   // ---------------------------------------------------------------------------
   assign rs1       = hz.id_instr[19:15];
   assign rs2       = hz.id_instr[24:20];
   assign is_branch = (hz.id_instr[6:2] == 5'b11000);

   // x0 is hardwired to zero, so a write to it never creates a dependency.
   assign match_rs1 = hz.ex_reg_write && (hz.ex_rd != 5'd0) && (hz.ex_rd == rs1);
   assign match_rs2 = hz.ex_reg_write && (hz.ex_rd != 5'd0) && (hz.ex_rd == rs2);

   // A load result is not available until after MEM, so no forwarding path
   // can cover it; applies to every instruction type.
   assign load_use  = hz.ex_mem_read && (match_rs1 || match_rs2);

`ifdef BRANCH_FWD_EN
   // ALU results of the EX instruction are fed back to the branch comparator.
   assign stall_cond = load_use;
   assign fwd_sel    = (is_branch && !load_use) ? {match_rs2, match_rs1} : 2'b00;
`else
   // No comparator feedback path: a branch must wait for the EX result.
   assign stall_cond = load_use || (is_branch && (match_rs1 || match_rs2));
   assign fwd_sel    = 2'b00;
`endif

   assign in_run    = (state_q == StRun);
   assign stall_out = in_run && stall_cond;
   assign mp_accept = in_run && !stall_cond && is_branch && hz.br_mispredict;

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StRun;
         fcnt_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         StRun: begin
            if (stall_cond) begin
               state_d = StStall;
            end else if (mp_accept) begin
               state_d = StFlush;
               fcnt_d  = 2'd0;
            end
         end
         StStall: begin
            state_d = StRun;
         end
         StFlush: begin
            if (fcnt_q == FlushLast) begin
               state_d = StRun;
               fcnt_d  = 2'd0;
            end else begin
               fcnt_d = fcnt_q + 2'd1;
            end
         end
         default: begin
            state_d = StRun;
            fcnt_d  = 2'd0;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // FSM: outputs
   // ---------------------------------------------------------------------------
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_e = 1'b0;
      flush_f = 1'b0;
      flush_d = 1'b0;
      pc_sel  = 1'b0;
      dhazard = 2'b00;
      // The state already resets asynchronously, but the input-driven terms
      // would still leak through while reset is held; gate them explicitly.
      if (rst_n) begin
         stall_f = stall_out;
         stall_d = stall_out;
         flush_e = stall_out;
         pc_sel  = mp_accept;
         flush_f = mp_accept || (state_q == StFlush);
         flush_d = mp_accept || (state_q == StFlush);
         dhazard = fwd_sel;
      end
   end

   // ---------------------------------------------------------------------------
   // Saturating performance counters
   // ---------------------------------------------------------------------------
   always_comb begin
      flush_cnt_d = flush_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (mp_accept && (flush_cnt_q != {CNT_W{1'b1}})) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
      if ((state_q == StStall) && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         flush_cnt_q <= flush_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Interface outputs
   // ---------------------------------------------------------------------------
   assign hz.stallF         = stall_f;
   assign hz.stallD         = stall_d;
   assign hz.flushF         = flush_f;
   assign hz.flushD         = flush_d;
   assign hz.flushE         = flush_e;
   assign hz.pc_sel         = pc_sel;
   assign hz.branch_dhazard = dhazard;
   assign hz.flush_cnt      = flush_cnt_q;
   assign hz.stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl. Three instances share one stimulus:
//   u_dut_a  FLUSH_CYCLES=2, CNT_W=16
//   u_dut_b  FLUSH_CYCLES=1, CNT_W=16
//   u_dut_c  FLUSH_CYCLES=1, CNT_W=4
// Inputs change 1 time unit after a rising edge; outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   logic clk;
   logic rst_n;

   int unsigned n_checks;
   int unsigned n_pass;

   pipe_hazard_ctrl_if #(.CNT_W(16)) hz_a ();
   pipe_hazard_ctrl_if #(.CNT_W(16)) hz_b ();
   pipe_hazard_ctrl_if #(.CNT_W(4))  hz_c ();

   pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz_a)
   );

   pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz_b)
   );

   pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(4)) u_dut_c (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mk_instr(input logic [4:0] rs1, input logic [4:0] rs2,
                                            input logic br);
      logic [31:0] r;
      r        = 32'h0;
      r[19:15] = rs1;
      r[24:20] = rs2;
      r[6:0]   = br ? 7'b1100011 : 7'b0110011;
      return r;
   endfunction

   task automatic drive(input logic [31:0] instr, input logic [4:0] rd, input logic rw,
                        input logic mr, input logic mp);
      hz_a.id_instr = instr; hz_a.ex_rd = rd; hz_a.ex_reg_write = rw;
      hz_a.ex_mem_read = mr; hz_a.br_mispredict = mp;
      hz_b.id_instr = instr; hz_b.ex_rd = rd; hz_b.ex_reg_write = rw;
      hz_b.ex_mem_read = mr; hz_b.br_mispredict = mp;
      hz_c.id_instr = instr; hz_c.ex_rd = rd; hz_c.ex_reg_write = rw;
      hz_c.ex_mem_read = mr; hz_c.br_mispredict = mp;
   endtask

   task automatic idle();
      drive(32'h0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int unsigned exp_dh;
      int unsigned exp_st;

      n_checks = 0;
      n_pass   = 0;
      rst_n    = 1'b0;

      // Reset held with a load-use plus mispredict present: everything stays low.
      drive(mk_instr(5'd5, 5'd0, 1'b1), 5'd5, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      check("rst_stallF",    32'(hz_a.stallF), 0);
      check("rst_flushE",    32'(hz_a.flushE), 0);
      check("rst_flushF",    32'(hz_a.flushF), 0);
      check("rst_pc_sel",    32'(hz_a.pc_sel), 0);
      check("rst_flush_cnt", 32'(hz_a.flush_cnt), 0);
      check("rst_stall_cnt", 32'(hz_a.stall_cnt), 0);

      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle();

      // Load-use: ex_rd=5 load, rs1=5.
      tick();
      drive(mk_instr(5'd5, 5'd0, 1'b0), 5'd5, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check("lu_stallF",  32'(hz_a.stallF), 1);
      check("lu_stallD",  32'(hz_a.stallD), 1);
      check("lu_flushE",  32'(hz_a.flushE), 1);
      check("lu_pc_sel",  32'(hz_a.pc_sel), 0);
      check("lu_flushF",  32'(hz_a.flushF), 0);
      tick();
      idle();
      @(negedge clk);
      check("lu_one_cycle", 32'(hz_a.stallF), 0);
      tick();
      @(negedge clk);
      check("lu_stall_cnt", 32'(hz_a.stall_cnt), 1);

      // Stall beats a same-cycle mispredict; mispredict ignored in STALL.
      tick();
      drive(mk_instr(5'd5, 5'd6, 1'b1), 5'd5, 1'b1, 1'b1, 1'b1);
      @(negedge clk);
      check("prio_stallF", 32'(hz_a.stallF), 1);
      check("prio_pc_sel", 32'(hz_a.pc_sel), 0);
      check("prio_flushF", 32'(hz_a.flushF), 0);
      tick();
      drive(mk_instr(5'd1, 5'd2, 1'b1), 5'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("stall_ign_mp_pc_sel", 32'(hz_a.pc_sel), 0);
      check("stall_ign_mp_flushF", 32'(hz_a.flushF), 0);
      tick();
      idle();
      @(negedge clk);
      check("prio_stall_cnt", 32'(hz_a.stall_cnt), 2);

      // Single mispredict, FLUSH_CYCLES=2 on instance a.
      tick();
      drive(mk_instr(5'd1, 5'd2, 1'b1), 5'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("mp0_pc_sel", 32'(hz_a.pc_sel), 1);
      check("mp0_flushF", 32'(hz_a.flushF), 1);
      check("mp0_flushD", 32'(hz_a.flushD), 1);
      check("mp0_flushE", 32'(hz_a.flushE), 0);
      tick();
      drive(mk_instr(5'd1, 5'd2, 1'b1), 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("mp1_pc_sel", 32'(hz_a.pc_sel), 0);
      check("mp1_flushF", 32'(hz_a.flushF), 1);
      check("mp1_flushD", 32'(hz_a.flushD), 1);
      tick();
      @(negedge clk);
      check("mp2_pc_sel", 32'(hz_a.pc_sel), 0);
      check("mp2_flushF", 32'(hz_a.flushF), 1);
      check("mp2_b_flushF", 32'(hz_b.flushF), 0);
      tick();
      idle();
      @(negedge clk);
      check("mp3_flushF",    32'(hz_a.flushF), 0);
      check("mp3_flush_cnt", 32'(hz_a.flush_cnt), 1);

      // Mispredict held four cycles, FLUSH_CYCLES=1 on instance b.
      tick();
      drive(mk_instr(5'd1, 5'd2, 1'b1), 5'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check($sformatf("held%0d_pc_sel", i), 32'(hz_b.pc_sel), ((i % 2) == 0) ? 1 : 0);
         check($sformatf("held%0d_flushF", i), 32'(hz_b.flushF), 1);
         tick();
      end
      idle();
      @(negedge clk);
      check("held_end_flushF",  32'(hz_b.flushF), 0);
      check("held_b_flush_cnt", 32'(hz_b.flush_cnt), 3);
      tick();
      tick();
      @(negedge clk);
      check("held_a_flushF",    32'(hz_a.flushF), 0);
      check("held_a_flush_cnt", 32'(hz_a.flush_cnt), 3);

      // Mispredict on a non-branch is not accepted.
      tick();
      drive(mk_instr(5'd1, 5'd2, 1'b0), 5'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("nonbr_pc_sel", 32'(hz_a.pc_sel), 0);
      check("nonbr_flushF", 32'(hz_a.flushF), 0);

      // Branch operand dependency on an ALU result in EX.
`ifdef BRANCH_FWD_EN
      exp_st = 0;
`else
      exp_st = 1;
`endif
      tick();
      drive(mk_instr(5'd7, 5'd7, 1'b1), 5'd7, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      exp_dh = (exp_st == 0) ? 3 : 0;
      check("fwd_both_dh",    32'(hz_a.branch_dhazard), exp_dh);
      check("fwd_both_stall", 32'(hz_a.stallF), exp_st);
      tick();
      idle();
      tick();
      drive(mk_instr(5'd3, 5'd7, 1'b1), 5'd7, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      exp_dh = (exp_st == 0) ? 2 : 0;
      check("fwd_rs2_dh",    32'(hz_a.branch_dhazard), exp_dh);
      check("fwd_rs2_stall", 32'(hz_a.stallF), exp_st);
      tick();
      idle();
      tick();
      drive(mk_instr(5'd7, 5'd3, 1'b1), 5'd7, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      exp_dh = (exp_st == 0) ? 1 : 0;
      check("fwd_rs1_dh",    32'(hz_a.branch_dhazard), exp_dh);
      check("fwd_rs1_stall", 32'(hz_a.stallF), exp_st);
      tick();
      idle();
      tick();
      drive(mk_instr(5'd0, 5'd0, 1'b1), 5'd0, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check("x0_dh",    32'(hz_a.branch_dhazard), 0);
      check("x0_stall", 32'(hz_a.stallF), 0);
      tick();
      drive(mk_instr(5'd7, 5'd7, 1'b1), 5'd7, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("nowr_dh",    32'(hz_a.branch_dhazard), 0);
      check("nowr_stall", 32'(hz_a.stallF), 0);
      tick();
      drive(mk_instr(5'd7, 5'd7, 1'b1), 5'd7, 1'b1, 1'b1, 1'b0);
      @(negedge clk);
      check("br_lu_dh",    32'(hz_a.branch_dhazard), 0);
      check("br_lu_stall", 32'(hz_a.stallF), 1);
      tick();
      idle();
      tick();

      // Reset asserted during FLUSH cycle 1 of instance a.
      tick();
      drive(mk_instr(5'd1, 5'd2, 1'b1), 5'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("rmid_accept", 32'(hz_a.pc_sel), 1);
      tick();
      drive(mk_instr(5'd1, 5'd2, 1'b1), 5'd0, 1'b0, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check("rmid_flushF",    32'(hz_a.flushF), 0);
      check("rmid_flushD",    32'(hz_a.flushD), 0);
      check("rmid_flush_cnt", 32'(hz_a.flush_cnt), 0);
      check("rmid_stall_cnt", 32'(hz_a.stall_cnt), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive(mk_instr(5'd1, 5'd2, 1'b1), 5'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("rmid_run_pc_sel", 32'(hz_a.pc_sel), 1);
      tick();
      idle();
      tick();
      tick();
      tick();

      // Twenty load-use stalls: 4-bit counter saturates, 16-bit counter does not.
      for (int i = 0; i < 20; i++) begin
         drive(mk_instr(5'd5, 5'd0, 1'b0), 5'd5, 1'b1, 1'b1, 1'b0);
         tick();
         idle();
         tick();
      end
      tick();
      @(negedge clk);
      check("sat_c_stall_cnt", 32'(hz_c.stall_cnt), 15);
      check("sat_a_stall_cnt", 32'(hz_a.stall_cnt), 20);
      check("sat_c_flush_cnt", 32'(hz_c.flush_cnt), 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
